branch_pc_unit: RTL

//  Producer side of the decoder's branch/flush interface: owns the PC register and the Z/V/N flag register.

---
 rtl/wisc_pkg.sv | 36 +++
 rtl/branch_pc_unit_if.sv | 27 ++
 rtl/branch_pc_unit_cond_eval.sv | 26 ++
 rtl/branch_pc_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC core definitions: opcodes, branch condition codes, flag bit layout and PC FSM states.
package wisc_pkg;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Flag vector layout is {Z,V,N}
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        COND_NE = 3'b000,
        COND_EQ = 3'b001,
        COND_GT = 3'b010,
        COND_LT = 3'b011,
        COND_GE = 3'b100,
        COND_LE = 3'b101,
        COND_OV = 3'b110,
        COND_AL = 3'b111
    } cond_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

    // Per-bit merge of a flag write onto the stored flags
    function automatic logic [2:0] merge_flags(input logic [2:0] stored,
                                               input logic [2:0] we,
                                               input logic [2:0] newv);
        return (newv & we) | (stored & ~we);
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Fetch/ID/EX-facing bus of the branch/PC unit; master drives pipeline inputs, slave is the unit.
interface branch_pc_if #(parameter int PC_W = 16) ();

    logic            stall_in;
    logic            id_valid;
    logic [3:0]      id_opcode;
    logic [2:0]      id_cond;
    logic [8:0]      id_imm9;
    logic [PC_W-1:0] id_rs_data;
    logic [2:0]      ex_flag_we;
    logic [2:0]      ex_flags;
    logic [PC_W-1:0] pc;
    logic            branch_taken;
    logic            flag_stall;
    logic            halted;

    modport master (
        output stall_in, id_valid, id_opcode, id_cond, id_imm9, id_rs_data, ex_flag_we, ex_flags,
        input  pc, branch_taken, flag_stall, halted
    );

    modport slave (
        input  stall_in, id_valid, id_opcode, id_cond, id_imm9, id_rs_data, ex_flag_we, ex_flags,
        output pc, branch_taken, flag_stall, halted
    );

endinterface

// File: rtl/branch_pc_unit_cond_eval.sv
// Pure combinational branch condition evaluation on a {Z,V,N} flag vector.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  cond_e      cond,
    input  logic [2:0] flags,
    output logic       take
);

    // Decode the condition code against the supplied flags
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_NE: take = ~flags[FLAG_Z];
            COND_EQ: take =  flags[FLAG_Z];
            COND_GT: take = ~flags[FLAG_Z] & ~flags[FLAG_N];
            COND_LT: take =  flags[FLAG_N];
            COND_GE: take =  flags[FLAG_Z] | ~flags[FLAG_N];
            COND_LE: take =  flags[FLAG_N] |  flags[FLAG_Z];
            COND_OV: take =  flags[FLAG_V];
            COND_AL: take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// PC, flag register and HLT FSM; resolves B/BR in ID and drives the same-cycle flush.
// Define FLAG_FWD_EN to evaluate conditions on forwarded EX flags instead of stalling.
module branch_pc_unit
    import wisc_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input logic       clk,
    input logic       rst_n,
    branch_pc_if.slave bus
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(32'd2);

    pc_state_e       state_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_of_id_r;
    logic [2:0]      flags_r;
    logic [2:0]      eval_flags_s;
    logic [PC_W-1:0] b_offset_s;
    logic [PC_W-1:0] target_s;
    logic [PC_W-1:0] pc_next_s;
    logic            run_s;
    logic            is_br_s;
    logic            take_s;
    logic            flag_stall_s;
    logic            branch_taken_s;
    logic            advance_s;

    assign run_s   = (state_r == RUN);
    assign is_br_s = bus.id_valid & ((bus.id_opcode == OP_B) | (bus.id_opcode == OP_BR));

`ifdef FLAG_FWD_EN
    assign eval_flags_s = merge_flags(flags_r, bus.ex_flag_we, bus.ex_flags);
    assign flag_stall_s = 1'b0;
`else
    // An in-flight flag write holds the branch one cycle so it resolves on settled flags
    assign eval_flags_s = flags_r;
    assign flag_stall_s = run_s & is_br_s & (bus.id_cond != COND_AL) & (|bus.ex_flag_we);
`endif

    branch_cond_eval u_cond_eval (
        .cond  (cond_e'(bus.id_cond)),
        .flags (eval_flags_s),
        .take  (take_s)
    );

    assign branch_taken_s = run_s & is_br_s & take_s & ~bus.stall_in & ~flag_stall_s;
    assign advance_s      = run_s & ~bus.stall_in & ~flag_stall_s;
    assign b_offset_s     = {{(PC_W-10){bus.id_imm9[8]}}, bus.id_imm9, 1'b0};

    // Branch target select and next-pc mux
    always_comb begin
        target_s  = pc_r;
        pc_next_s = pc_r;
        if (bus.id_opcode == OP_B) begin
            target_s = pc_of_id_r + PC_STEP + b_offset_s;
        end else begin
            target_s = bus.id_rs_data & ~{{(PC_W-1){1'b0}}, 1'b1};
        end
        if (!advance_s) begin
            pc_next_s = pc_r;
        end else if (branch_taken_s) begin
            pc_next_s = target_s;
        end else begin
            pc_next_s = pc_r + PC_STEP;
        end
    end

    // PC, ID-stage PC and RUN/HALT state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            pc_r       <= RESET_PC;
            pc_of_id_r <= RESET_PC - PC_STEP;
        end else begin
            pc_r <= pc_next_s;
            if (advance_s) begin
                pc_of_id_r <= pc_r;
            end else begin
                pc_of_id_r <= pc_of_id_r;
            end
            case (state_r)
                RUN: begin
                    if (bus.id_valid && (bus.id_opcode == OP_HLT) && !bus.stall_in) begin
                        state_r <= HALT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                HALT:    state_r <= HALT;
                default: state_r <= RUN;
            endcase
        end
    end

    // Flag register: each bit written independently, also while halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 3'b000;
        end else begin
            flags_r <= merge_flags(flags_r, bus.ex_flag_we, bus.ex_flags);
        end
    end

    assign bus.pc           = pc_r;
    assign bus.halted       = (state_r == HALT);
    assign bus.branch_taken = branch_taken_s;
    assign bus.flag_stall   = flag_stall_s;

endmodule
